wb_mem_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares the on-chip data memory.
- Master 0 is the core instruction-fetch port; master 1 is the core load/store port.
- It serialises their cycles onto the single memory Wishbone port using round-robin priority.
- A watchdog aborts any granted cycle whose strobe goes unacknowledged, so one master cannot lock the memory.

---
 rtl/wb_arb_pkg.sv | 34 +++
 rtl/wb_arb_wdog.sv | 38 +++
 rtl/wb_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
// State encoding, master indices and the round-robin pick helper.
package wb_arb_pkg;

  localparam int WDOG_W = 8;
  localparam int M0     = 0;
  localparam int M1     = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  // last=1 means m1 held the previous grant, so m0 wins a tie
  function automatic state_e arb_pick(
    input logic c0,
    input logic c1,
    input logic last
  );
    state_e s;
    s = ST_IDLE;
    if (c0 && c1) begin
      s = last ? ST_GNT0 : ST_GNT1;
    end else if (c0) begin
      s = ST_GNT0;
    end else if (c1) begin
      s = ST_GNT1;
    end
    return s;
  endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Strobe-without-ack watchdog: clearable counter with a terminal-count
// expire strobe. TIMEOUT of zero never expires.
module wb_arb_wdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_o
);

  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (clr) begin
      wdog_d = '0;
    end else if (en) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign expire_o = (TIMEOUT != 0) && en &&
                    (wdog_q == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the data memory,
// with a watchdog that aborts a granted strobe left unacknowledged.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic                  m0_we_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_cyc_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic                  m1_we_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_cyc_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic                  s_we_o,
  output logic                  s_stb_o,
  output logic                  s_cyc_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            gnt_o
);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] err_q, err_d;
  logic       expire;
  logic       wd_en;
  logic       wd_clr;

  always_comb begin
    state_d = state_q;
    err_d   = '0;
    unique case (state_q)
      ST_IDLE: state_d = arb_pick(m0_cyc_i, m1_cyc_i, last_q);
      ST_GNT0: begin
        if (expire) begin
          state_d   = ST_ABORT;
          err_d[M0] = 1'b1;
        end else if (!m0_cyc_i) begin
          state_d = arb_pick(1'b0, m1_cyc_i, last_q);
        end
      end
      ST_GNT1: begin
        if (expire) begin
          state_d   = ST_ABORT;
          err_d[M1] = 1'b1;
        end else if (!m1_cyc_i) begin
          state_d = arb_pick(m0_cyc_i, 1'b0, last_q);
        end
      end
      ST_ABORT: begin
        if (!(last_q ? m1_cyc_i : m0_cyc_i)) begin
          state_d = arb_pick(m0_cyc_i, m1_cyc_i, last_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    last_d = last_q;
    if (state_d == ST_GNT0 && state_q != ST_GNT0) last_d = 1'b0;
    if (state_d == ST_GNT1 && state_q != ST_GNT1) last_d = 1'b1;
    gnt_d = {state_d == ST_GNT1, state_d == ST_GNT0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (gnt_q[M0]) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_stb_o = m0_stb_i;
      s_cyc_o = m0_cyc_i;
    end else if (gnt_q[M1]) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_stb_o = m1_stb_i;
      s_cyc_o = m1_cyc_i;
    end
  end

  assign m0_ack_o = gnt_q[M0] & s_ack_i;
  assign m1_ack_o = gnt_q[M1] & s_ack_i;
  assign m0_dat_o = gnt_q[M0] ? s_dat_i : '0;
  assign m1_dat_o = gnt_q[M1] ? s_dat_i : '0;
  assign m0_err_o = err_q[M0];
  assign m1_err_o = err_q[M1];
  assign gnt_o    = gnt_q;

  assign wd_en  = (|gnt_q) & s_stb_o & ~s_ack_i;
  assign wd_clr = ~(|gnt_q) | s_ack_i | (state_d != state_q);

  wb_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wd_clr),
    .en       (wd_en),
    .expire_o (expire)
  );

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench: a TIMEOUT=4 arbiter with a memory model, and a
// TIMEOUT=0 arbiter whose memory never acknowledges.
module tb_wb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat;
  logic        m0_we, m0_stb, m0_cyc;
  logic        m1_we, m1_stb, m1_cyc;

  logic [31:0] a_m0_dat, a_m1_dat, a_s_dat, a_s_rd;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic [15:0] a_s_adr;
  logic        a_s_we, a_s_stb, a_s_cyc, a_s_ack;
  logic [1:0]  a_gnt;

  logic [31:0] b_m0_dat, b_m1_dat, b_s_dat;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [15:0] b_s_adr;
  logic        b_s_we, b_s_stb, b_s_cyc;
  logic [1:0]  b_gnt;

  logic        ack_block = 1'b0;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;
  int bad;

  wb_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_we_o(a_s_we),
    .s_stb_o(a_s_stb), .s_cyc_o(a_s_cyc),
    .s_dat_i(a_s_rd), .s_ack_i(a_s_ack), .gnt_o(a_gnt)
  );

  wb_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_we_o(b_s_we),
    .s_stb_o(b_s_stb), .s_cyc_o(b_s_cyc),
    .s_dat_i(32'h0), .s_ack_i(1'b0), .gnt_o(b_gnt)
  );

  // Memory: registered ack held while stb stays high
  always @(posedge clk) begin
    a_s_ack <= a_s_stb & a_s_cyc & ~ack_block;
    a_s_rd  <= mem[a_s_adr[7:2]];
    if (rst) begin
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'hCAFEF00D;
    end else if (a_s_stb && a_s_we) begin
      mem[a_s_adr[7:2]] <= a_s_dat;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m0_set(input logic c, input logic s, input logic w,
                        input logic [15:0] a, input logic [31:0] d);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat = d;
  endtask

  task automatic m1_set(input logic c, input logic s, input logic w,
                        input logic [15:0] a, input logic [31:0] d);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat = d;
  endtask

  initial begin
    m0_set(0, 0, 0, 16'h0, 32'h0);
    m1_set(0, 0, 0, 16'h0, 32'h0);
    tick;
    tick;
    chk("rst_gnt", a_gnt, 2'b00);
    chk("rst_err0", a_m0_err, 1'b0);
    chk("rst_err1", a_m1_err, 1'b0);
    chk("rst_stb", a_s_stb, 1'b0);
    chk("rst_cyc", a_s_cyc, 1'b0);
    rst = 1'b0;

    m0_set(1, 1, 0, 16'h0010, 32'h0);
    tick;
    chk("rd_gnt", a_gnt, 2'b01);
    chk("rd_stb", a_s_stb, 1'b1);
    chk("rd_adr", a_s_adr, 16'h0010);
    chk("rd_ack_early", a_m0_ack, 1'b0);
    tick;
    chk("rd_ack", a_m0_ack, 1'b1);
    chk("rd_dat", a_m0_dat, 32'hDEADBEEF);
    chk("rd_m1_ack", a_m1_ack, 1'b0);
    m0_set(0, 0, 0, 16'h0, 32'h0);
    tick;
    chk("rd_idle", a_gnt, 2'b00);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    m0_set(1, 1, 0, 16'h0010, 32'h0);
    m1_set(1, 1, 0, 16'h0020, 32'h0);
    tick;
    chk("ct_first", a_gnt, 2'b01);
    tick;
    chk("ct_m0_ack", a_m0_ack, 1'b1);
    chk("ct_m1_wait", a_m1_ack, 1'b0);
    m0_set(0, 0, 0, 16'h0, 32'h0);
    tick;
    chk("ct_no_bubble", a_gnt, 2'b10);
    chk("ct_adr1", a_s_adr, 16'h0020);
    tick;
    chk("ct_m1_ack", a_m1_ack, 1'b1);
    chk("ct_m1_dat", a_m1_dat, 32'hCAFEF00D);
    chk("ct_m0_noack", a_m0_ack, 1'b0);
    m1_set(0, 0, 0, 16'h0, 32'h0);
    tick;
    chk("ct_idle", a_gnt, 2'b00);
    m0_set(1, 1, 0, 16'h0010, 32'h0);
    m1_set(1, 1, 0, 16'h0020, 32'h0);
    tick;
    chk("ct_rr_m0", a_gnt, 2'b01);
    tick;
    m0_set(0, 0, 0, 16'h0, 32'h0);
    tick;
    chk("ct_rr_m1", a_gnt, 2'b10);
    m1_set(0, 0, 0, 16'h0, 32'h0);
    tick;

    m1_set(1, 1, 1, 16'h0004, 32'h11111111);
    tick;
    chk("gh_gnt", a_gnt, 2'b10);
    m0_set(1, 1, 0, 16'h0010, 32'h0);
    tick;
    chk("gh_ack1", a_m1_ack, 1'b1);
    chk("gh_hold1", a_gnt, 2'b10);
    m1_set(1, 0, 1, 16'h0004, 32'h11111111);
    tick;
    chk("gh_hold2", a_gnt, 2'b10);
    chk("gh_noack", a_m1_ack, 1'b0);
    m1_set(1, 1, 1, 16'h0008, 32'h22222222);
    tick;
    chk("gh_ack2", a_m1_ack, 1'b1);
    chk("gh_hold3", a_gnt, 2'b10);
    chk("gh_adr2", a_s_adr, 16'h0008);
    m1_set(0, 0, 0, 16'h0, 32'h0);
    tick;
    chk("gh_swap", a_gnt, 2'b01);
    chk("gh_mem1", mem[1], 32'h11111111);
    chk("gh_mem2", mem[2], 32'h22222222);
    tick;
    chk("gh_m0_ack", a_m0_ack, 1'b1);
    chk("gh_m0_dat", a_m0_dat, 32'hDEADBEEF);
    m0_set(0, 0, 0, 16'h0, 32'h0);
    tick;

    ack_block = 1'b1;
    m0_set(1, 1, 0, 16'h0010, 32'h0);
    tick;
    chk("to_gnt", a_gnt, 2'b01);
    chk("to_stb", a_s_stb, 1'b1);
    chk("to_err_c1", a_m0_err, 1'b0);
    m1_set(1, 1, 0, 16'h0020, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("to_err_wait", a_m0_err, 1'b0);
    end
    tick;
    chk("to_err", a_m0_err, 1'b1);
    chk("to_stb_off", a_s_stb, 1'b0);
    chk("to_gnt_off", a_gnt, 2'b00);
    tick;
    chk("to_err_once", a_m0_err, 1'b0);
    chk("to_m1_held", a_gnt, 2'b00);
    m0_set(0, 0, 0, 16'h0, 32'h0);
    ack_block = 1'b0;
    tick;
    chk("to_m1_gnt", a_gnt, 2'b10);
    chk("to_m1_err", a_m1_err, 1'b0);

    rst = 1'b1;
    tick;
    chk("mr_gnt", a_gnt, 2'b00);
    chk("mr_stb", a_s_stb, 1'b0);
    chk("mr_cyc", a_s_cyc, 1'b0);
    chk("mr_adr", a_s_adr, 16'h0);
    chk("mr_we", a_s_we, 1'b0);
    chk("mr_ack", a_m1_ack, 1'b0);
    chk("mr_err", a_m1_err, 1'b0);
    rst = 1'b0;
    m0_set(1, 1, 0, 16'h0010, 32'h0);
    tick;
    chk("mr_m0_first", a_gnt, 2'b01);
    m0_set(0, 0, 0, 16'h0, 32'h0);
    m1_set(0, 0, 0, 16'h0, 32'h0);
    tick;

    rst = 1'b1;
    tick;
    rst = 1'b0;
    m0_set(1, 1, 0, 16'h0010, 32'h0);
    bad = 0;
    repeat (300) begin
      tick;
      if (b_m0_err !== 1'b0 || b_gnt !== 2'b01) bad++;
    end
    chk("wd_off_bad", bad, 0);
    chk("wd_off_gnt", b_gnt, 2'b01);
    chk("wd_off_err", b_m0_err, 1'b0);
    m0_set(0, 0, 0, 16'h0, 32'h0);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
